// File: rtl/ahb_bus_matrix_arb_rr_burst.sv
// Round-robin arbiter for one AHB bus-matrix output stage.
// Holds the grant across locked sequences and defined-length bursts; re-arbitrates only when HREADYM=1.
module ahb_bus_matrix_arb_rr_burst #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter bit          BURST_HOLD = 1'b1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [1:0]           addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] last_grant_nxt;
    logic [IDX_W-1:0] addr_nxt;
    logic [IDX_W-1:0] cand;
    logic             no_port_nxt;
    logic             hold_next;
    logic             hit;

    // Beats remaining in the current defined-length burst
    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (HREADYM) begin
            if (!BURST_HOLD) begin
                beat_cnt_nxt = '0;
            end else if (HSELM && (HTRANSM == TRANS_NONSEQ)) begin
                case (HBURSTM)
                    3'b010, 3'b011: beat_cnt_nxt = CNT_W'(3);
                    3'b100, 3'b101: beat_cnt_nxt = CNT_W'(7);
                    3'b110, 3'b111: beat_cnt_nxt = CNT_W'(15);
                    default:        beat_cnt_nxt = '0;
                endcase
            end else if ((HTRANSM == TRANS_SEQ) && (beat_cnt != '0)) begin
                beat_cnt_nxt = beat_cnt - CNT_W'(1);
            end else if (HTRANSM == TRANS_BUSY) begin
                beat_cnt_nxt = beat_cnt;
            end else begin
                beat_cnt_nxt = '0;
            end
        end
    end

    assign hold_next = (beat_cnt_nxt != '0) | HMASTLOCKM;

    // Grant selection: keep the owner while holding, else search from last_grant+1
    always_comb begin
        addr_nxt       = addr_in_port;
        last_grant_nxt = last_grant;
        no_port_nxt    = no_port;
        hit            = 1'b0;
        cand           = '0;
        if (HREADYM && !(hold_next && !no_port)) begin
            for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
                cand = IDX_W'((32'(last_grant) + i) % NUM_PORTS);
                if (!hit && req_port[cand]) begin
                    hit      = 1'b1;
                    addr_nxt = cand;
                end
            end
            if (hit) begin
                no_port_nxt    = 1'b0;
                last_grant_nxt = addr_nxt;
            end else begin
                no_port_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            burst_hold   <= 1'b0;
            last_grant   <= IDX_W'(NUM_PORTS - 1);
            beat_cnt     <= '0;
        end else begin
            beat_cnt <= beat_cnt_nxt;
            if (HREADYM) begin
                addr_in_port <= addr_nxt;
                no_port      <= no_port_nxt;
                last_grant   <= last_grant_nxt;
                burst_hold   <= (beat_cnt_nxt != '0);
            end
        end
    end

endmodule
